cholesky_arith_sequencer: RTL and testbench

- Counterpart of the Cholesky datapath's arithmetic interface: owns the step sequence (drives en, rst, step) and serves the operand requests the datapath issues.
- Returns 15 fixed-point products and 5 fixed-point quotients per step.
- Sits between the host control registers and the Cholesky core; contains the pipelined multiplier array and the shared-divisor restoring divider.

---
 rtl/cholesky_pkg.sv | 26 ++
 rtl/cholesky_div_lane.sv | 97 +++++++++
 rtl/cholesky_arith_sequencer.sv | 157 +++++++++++++++
 tb/tb_cholesky_arith_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cholesky_pkg.sv
// Shared constants and types for the Cholesky arithmetic sequencer.
// Provides the fixed-point word format (Q10.16, signed), its saturation
// limits, the divider iteration count and the sequencer state encoding.
package cholesky_pkg;

    localparam int unsigned WIDTH     = 27;
    localparam int unsigned FRAC_BITS = 16;
    // One iteration per quotient bit of (|dividend| << FRAC_BITS).
    localparam int unsigned DIV_ITERS = WIDTH + FRAC_BITS;

    typedef logic signed [WIDTH-1:0] fx_t;

    localparam fx_t MAX_FX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam fx_t MIN_FX = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StMwait,
        StDiv,
        StAdv,
        StDone
    } state_t;

endpackage

// File: rtl/cholesky_div_lane.sv
// Single-lane restoring divider: quotient = (dividend << FRAC_BITS) / divisor.
// Works on magnitudes, applies sign = sign(dividend) ^ sign(divisor),
// truncates toward zero and saturates to the fx_t range. A zero divisor
// yields MAX_FX (dividend >= 0) or MIN_FX and raises div_zero.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      sample operands and restart the iteration counter
//   en         perform one iteration per cycle while high
//   dividend   signed dividend, sampled on start
//   divisor    signed divisor, sampled on start
//   done       high during the final iteration cycle
//   quotient   registered result, updated on the final iteration edge
//   div_zero   the sampled divisor was zero
module cholesky_div_lane
    import cholesky_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    input  fx_t  dividend,
    input  fx_t  divisor,
    output logic done,
    output fx_t  quotient,
    output logic div_zero
);

    localparam int unsigned NW = DIV_ITERS;
    localparam int unsigned CW = $clog2(DIV_ITERS);
    localparam logic [NW-1:0] MAG_MAX = NW'(2 ** (WIDTH - 1) - 1);
    localparam logic [NW-1:0] MAG_MIN = NW'(2 ** (WIDTH - 1));

    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [NW-1:0]    num_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             dneg_q;
    logic             zero_q;

    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] ds_mag;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;
    logic [NW-1:0]    num_nx;
    fx_t              q_fin;

    always_comb begin
        dd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        ds_mag = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
        // Quotient bits shift into num_q from the bottom as numerator bits leave the top.
        rem_sh = {rem_q, num_q[NW-1]};
        ge     = rem_sh >= {1'b0, dvs_q};
        rem_nx = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
        num_nx = {num_q[NW-2:0], ge};
        done   = en && (cnt_q == CW'(NW - 1));
        if (zero_q) begin
            q_fin = dneg_q ? MIN_FX : MAX_FX;
        end else if (!neg_q) begin
            q_fin = (num_nx > MAG_MAX) ? MAX_FX : fx_t'(num_nx[WIDTH-1:0]);
        end else begin
            q_fin = (num_nx > MAG_MIN) ? MIN_FX : fx_t'(~num_nx[WIDTH-1:0] + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvs_q    <= '0;
            rem_q    <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dneg_q   <= 1'b0;
            zero_q   <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            dvs_q  <= ds_mag;
            rem_q  <= '0;
            num_q  <= {dd_mag, {FRAC_BITS{1'b0}}};
            cnt_q  <= '0;
            neg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dneg_q <= dividend[WIDTH-1];
            zero_q <= (divisor == '0);
        end else if (en) begin
            rem_q <= rem_nx;
            num_q <= num_nx;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                quotient <= q_fin;
            end
        end
    end

    assign div_zero = zero_q;

endmodule

// File: rtl/cholesky_arith_sequencer.sv
// Arithmetic sequencer for the Cholesky datapath. Steps the datapath through
// N_STEPS steps (chol_rst / chol_en / step) and serves each step with
// N_MULT saturated fixed-point products and N_DIV shared-divisor quotients.
// Optional build macro: CHOLESKY_MULT_ROUND_EN -- products round to nearest
// (ties away from zero) instead of truncating; latency is unchanged.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               host request (rising edge starts a run while idle)
//   busy, done          run in progress / one-cycle completion pulse
//   div_zero            sticky divide-by-zero flag for the current run
//   chol_en, chol_rst   datapath step strobe and clear
//   step                current step index
//   array_mult_*        multiplier operands and products
//   dividends, divisor  divider operands; quotients results
module cholesky_arith_sequencer
    import cholesky_pkg::*;
#(
    parameter int unsigned N_MULT   = 15,
    parameter int unsigned N_DIV    = 5,
    parameter int unsigned MULT_LAT = 3,
    parameter int unsigned N_STEPS  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    div_zero,
    output logic                    chol_en,
    output logic                    chol_rst,
    output logic [4:0]              step,
    input  logic [N_MULT*WIDTH-1:0] array_mult_dataa,
    input  logic [N_MULT*WIDTH-1:0] array_mult_datab,
    output logic [N_MULT*WIDTH-1:0] array_mult_result,
    input  logic [N_DIV*WIDTH-1:0]  dividends,
    input  logic [WIDTH-1:0]        divisor,
    output logic [N_DIV*WIDTH-1:0]  quotients
);

    state_t              state_q, state_d;
    logic [4:0]          step_q;
    logic                start_q;
    logic                div_zero_q;
    logic [MULT_LAT-1:0] vld_q;
    logic [N_DIV-1:0]    lane_done;
    logic [N_DIV-1:0]    lane_zero;
    logic                issue;
    logic                div_run;

    assign issue   = (state_q == StIssue);
    assign div_run = (state_q == StDiv);

    function automatic fx_t mul_fx(input fx_t a, input fx_t b);
        logic signed [2*WIDTH-1:0] ax, bx, p, s;
`ifdef CHOLESKY_MULT_ROUND_EN
        logic [2*WIDTH-1:0] mag;
`endif
        ax = {{WIDTH{a[WIDTH-1]}}, a};
        bx = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ax * bx;
`ifdef CHOLESKY_MULT_ROUND_EN
        mag = p[2*WIDTH-1] ? -p : p;
        mag = (mag + (2*WIDTH)'(2 ** (FRAC_BITS - 1))) >> FRAC_BITS;
        s   = p[2*WIDTH-1] ? -$signed(mag) : $signed(mag);
`else
        s = p >>> FRAC_BITS;
`endif
        if (s > MAX_FX) begin
            return MAX_FX;
        end else if (s < MIN_FX) begin
            return MIN_FX;
        end
        return fx_t'(s[WIDTH-1:0]);
    endfunction

    // Each lane's stages only load when a valid product arrives, so the last
    // stage holds its value until the next step's product lands.
    for (genvar l = 0; l < N_MULT; l++) begin : g_mul
        fx_t prod;
        fx_t pipe_q [MULT_LAT];
        assign prod = mul_fx(fx_t'(array_mult_dataa[l*WIDTH +: WIDTH]),
                             fx_t'(array_mult_datab[l*WIDTH +: WIDTH]));
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < MULT_LAT; s++) pipe_q[s] <= '0;
            end else begin
                if (issue) pipe_q[0] <= prod;
                for (int s = 1; s < MULT_LAT; s++) begin
                    if (vld_q[s-1]) pipe_q[s] <= pipe_q[s-1];
                end
            end
        end
        assign array_mult_result[l*WIDTH +: WIDTH] = pipe_q[MULT_LAT-1];
    end

    for (genvar d = 0; d < N_DIV; d++) begin : g_div
        cholesky_div_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .start    (issue),
            .en       (div_run),
            .dividend (fx_t'(dividends[d*WIDTH +: WIDTH])),
            .divisor  (fx_t'(divisor)),
            .done     (lane_done[d]),
            .quotient (quotients[d*WIDTH +: WIDTH]),
            .div_zero (lane_zero[d])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            step_q     <= '0;
            start_q    <= 1'b0;
            div_zero_q <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            for (int s = MULT_LAT - 1; s > 0; s--) vld_q[s] <= vld_q[s-1];
            vld_q[0] <= issue;
            if (state_q == StClear) begin
                step_q     <= '0;
                div_zero_q <= 1'b0;
            end else begin
                if (state_q == StAdv && step_q != 5'(N_STEPS - 1)) step_q <= step_q + 1'b1;
                if (|(lane_done & lane_zero)) div_zero_q <= 1'b1;
            end
        end
    end

    // A start held high across a whole run must not retrigger, so only its
    // rising edge is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !start_q) state_d = StClear;
            StClear: state_d = StIssue;
            StIssue: state_d = StMwait;
            StMwait: if (vld_q[MULT_LAT-1]) state_d = StDiv;
            StDiv:   if (&lane_done) state_d = StAdv;
            StAdv:   state_d = (step_q == 5'(N_STEPS - 1)) ? StDone : StIssue;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = !rst && (state_q != StIdle) && (state_q != StDone);
        done     = !rst && (state_q == StDone);
        chol_en  = !rst && (state_q == StIssue);
        chol_rst = rst || (state_q == StClear);
        step     = step_q;
        div_zero = div_zero_q;
    end

endmodule

// File: tb/tb_cholesky_arith_sequencer.sv
// Directed self-checking bench for cholesky_arith_sequencer.
module tb_cholesky_arith_sequencer;
    import cholesky_pkg::*;

    localparam int NM = 15;
    localparam int ND = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done, div_zero, chol_en, chol_rst;
    logic [4:0]      step;
    logic [NM*27-1:0] dataa, datab, result;
    logic [ND*27-1:0] dvd, quo;
    logic [26:0]     dvs;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int dk, nd, mx, dz_at_done, busy_at_done;

    always #5 clk = ~clk;

    cholesky_arith_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .div_zero          (div_zero),
        .chol_en           (chol_en),
        .chol_rst          (chol_rst),
        .step              (step),
        .array_mult_dataa  (dataa),
        .array_mult_datab  (datab),
        .array_mult_result (result),
        .dividends         (dvd),
        .divisor           (dvs),
        .quotients         (quo)
    );

    function automatic logic [26:0] res(input int i);
        return result[i*27 +: 27];
    endfunction

    function automatic logic [26:0] qo(input int i);
        return quo[i*27 +: 27];
    endfunction

    task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic adv_to(input int target);
        while (k < target) tick();
    endtask

    // Runs until k reaches 700, recording every done pulse.
    task automatic wait_done();
        nd = 0; dk = -1; mx = 0; dz_at_done = -1; busy_at_done = -1;
        while (k < 700) begin
            tick();
            if (int'(step) > mx) mx = int'(step);
            if (done === 1'b1) begin
                nd++;
                dk = k;
                dz_at_done = int'(div_zero);
                busy_at_done = int'(busy);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        k = 0;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dataa = '0;
        datab = '0;
        dvd = '0;
        dvs = '0;
        repeat (3) @(negedge clk);
        chk("rst_chol_rst", 27'(chol_rst), 27'(1));
        chk("rst_busy", 27'(busy), 27'(0));
        chk("rst_chol_en", 27'(chol_en), 27'(0));
        rst = 1'b0;
        tick();
        chk("idle_chol_rst", 27'(chol_rst), 27'(0));
        chk("idle_step", 27'(step), 27'(0));
        chk("idle_res0", res(0), 27'(0));
        chk("idle_q0", qo(0), 27'(0));
        chk("idle_dz", 27'(div_zero), 27'(0));

        // Run 1: products and quotients with divisor 4.0, then 2.0.
        dataa[0*27 +: 27] = 27'(131072);   datab[0*27 +: 27] = 27'(196608);
        dataa[1*27 +: 27] = 27'h3FFFFFF;   datab[1*27 +: 27] = 27'h3FFFFFF;
        dataa[2*27 +: 27] = 27'(-1);       datab[2*27 +: 27] = 27'(1);
        dataa[3*27 +: 27] = 27'(-131072);  datab[3*27 +: 27] = 27'(196608);
        dvd[0*27 +: 27] = 27'(65536);
        dvd[1*27 +: 27] = 27'(-196608);
        dvs = 27'(262144);
        pulse_start();
        chk("clear_chol_rst", 27'(chol_rst), 27'(1));
        chk("clear_busy", 27'(busy), 27'(1));
        tick();
        chk("issue_chol_en", 27'(chol_en), 27'(1));
        chk("issue_step", 27'(step), 27'(0));
        adv_to(4);
        chk("res0_early", res(0), 27'(0));
        tick();
        chk("res0_2x3", res(0), 27'(393216));
        chk("res1_sat", res(1), 27'h3FFFFFF);
`ifdef CHOLESKY_MULT_ROUND_EN
        chk("res2_lsb", res(2), 27'(0));
`else
        chk("res2_lsb", res(2), 27'(-1));
`endif
        chk("res3_neg", res(3), 27'(-393216));
        adv_to(48);
        chk("q0_early", qo(0), 27'(0));
        tick();
        chk("q0_1_div4", qo(0), 27'(16384));
        chk("q1_m3_div4", qo(1), 27'(-49152));
        chk("dz_run1", 27'(div_zero), 27'(0));
        chk("res0_hold", res(0), 27'(393216));
        dvs = 27'(131072);
        adv_to(97);
        chk("q0_1_div2", qo(0), 27'(32768));
        chk("q1_m3_div2", qo(1), 27'(-98304));
        wait_done();
        chk("run1_done_cycle", 27'(dk), 27'(578));
        chk("run1_done_count", 27'(nd), 27'(1));
        chk("run1_max_step", 27'(mx), 27'(11));
        chk("run1_busy_at_done", 27'(busy_at_done), 27'(0));

        // Run 2: divide by zero.
        dvd[0*27 +: 27] = 27'(327680);
        dvd[1*27 +: 27] = 27'(-65536);
        dvs = '0;
        pulse_start();
        adv_to(49);
        chk("q0_div0", qo(0), 27'h3FFFFFF);
        chk("q1_div0", qo(1), 27'h4000000);
        chk("dz_set", 27'(div_zero), 27'(1));
        wait_done();
        chk("dz_at_done", 27'(dz_at_done), 27'(1));
        chk("run2_done_count", 27'(nd), 27'(1));

        // Run 3: start held high for the whole run.
        dvd[0*27 +: 27] = 27'(65536);
        dvd[1*27 +: 27] = 27'(-196608);
        dvs = 27'(131072);
        start = 1'b1;
        k = 0;
        adv_to(2);
        chk("dz_cleared", 27'(div_zero), 27'(0));
        wait_done();
        chk("held_done_count", 27'(nd), 27'(1));
        chk("held_done_cycle", 27'(dk), 27'(578));
        chk("held_busy_after", 27'(busy), 27'(0));
        start = 1'b0;
        tick();

        // Run 4: reset during DIV of step 5.
        pulse_start();
        adv_to(259);
        chk("abort_step5", 27'(step), 27'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 27'(busy), 27'(0));
        chk("abort_step", 27'(step), 27'(0));
        chk("abort_res0", res(0), 27'(0));
        chk("abort_q0", qo(0), 27'(0));
        chk("abort_done", 27'(done), 27'(0));
        k = 640;
        wait_done();
        chk("abort_no_done", 27'(nd), 27'(0));

        // Run 5: normal run after the abort.
        pulse_start();
        wait_done();
        chk("run5_done_cycle", 27'(dk), 27'(578));
        chk("run5_done_count", 27'(nd), 27'(1));
        chk("run5_q0", qo(0), 27'(32768));
        chk("run5_res0", res(0), 27'(393216));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
